// File: rtl/reg_file_2r1w_pkg.sv
// Shared sizing and constants for the 2-read / 1-write register file.
package reg_file_2r1w_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [DATA_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/dff_en_sr.sv
// Single-bit D flip-flop with load enable and synchronous active-low clear.
module dff_en_sr (
  input  logic CLK,
  input  logic R,
  input  logic EN,
  input  logic D,
  output logic Q,
  output logic Q_
);

  always_ff @(posedge CLK) begin
    if (!R) begin
      Q <= 1'b0;
    end else if (EN) begin
      Q <= D;
    end
  end

  assign Q_ = ~Q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file: 2^ADDR_W entries, one synchronous write port, two registered
// read ports with write-first forwarding; register 0 always reads as zero.
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W
) (
  input  logic                CLK,
  input  logic                R,
  input  logic                WE,
  input  logic [ADDR_W_P-1:0] WA,
  input  logic [DATA_W_P-1:0] WD,
  input  logic [ADDR_W_P-1:0] RA1,
  input  logic [ADDR_W_P-1:0] RA2,
  output logic [DATA_W_P-1:0] RD1,
  output logic [DATA_W_P-1:0] RD2
);

  localparam int DEPTH_P = 1 << ADDR_W_P;

  logic [DEPTH_P-1:0]  wen;
  logic [DATA_W_P-1:0] regs       [DEPTH_P];
  logic [DATA_W_P-1:0] regs_unused [DEPTH_P];
  logic [DATA_W_P-1:0] rd1_next;
  logic [DATA_W_P-1:0] rd2_next;
  logic [DATA_W_P-1:0] rd1_unused;
  logic [DATA_W_P-1:0] rd2_unused;

  always_comb begin
    wen = '0;
    if (WE) begin
      wen[WA] = 1'b1;
    end
    wen[0] = 1'b0;
  end

  // Entry 0 has no storage: it is the architectural zero register.
  genvar gi, gb;
  generate
    for (gi = 0; gi < DEPTH_P; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs[gi]        = DATA_W_P'(REG_ZERO);
        assign regs_unused[gi] = '1;
      end else begin : g_store
        for (gb = 0; gb < DATA_W_P; gb++) begin : g_bit
          dff_en_sr u_bit (
            .CLK (CLK),
            .R   (R),
            .EN  (wen[gi]),
            .D   (WD[gb]),
            .Q   (regs[gi][gb]),
            .Q_  (regs_unused[gi][gb])
          );
        end
      end
    end
  endgenerate

  // Write-first: a same-edge write to the addressed register is forwarded.
  always_comb begin
    rd1_next = regs[RA1];
    if (RA1 == '0) begin
      rd1_next = DATA_W_P'(REG_ZERO);
    end else if (WE && (WA == RA1)) begin
      rd1_next = WD;
    end
  end

  always_comb begin
    rd2_next = regs[RA2];
    if (RA2 == '0) begin
      rd2_next = DATA_W_P'(REG_ZERO);
    end else if (WE && (WA == RA2)) begin
      rd2_next = WD;
    end
  end

  generate
    for (gb = 0; gb < DATA_W_P; gb++) begin : g_rd
      dff_en_sr u_rd1 (
        .CLK (CLK),
        .R   (R),
        .EN  (1'b1),
        .D   (rd1_next[gb]),
        .Q   (RD1[gb]),
        .Q_  (rd1_unused[gb])
      );
      dff_en_sr u_rd2 (
        .CLK (CLK),
        .R   (R),
        .EN  (1'b1),
        .D   (rd2_next[gb]),
        .Q   (RD2[gb]),
        .Q_  (rd2_unused[gb])
      );
    end
  endgenerate

endmodule
